ssio_sdr_in_diff_align: RTL and testbench
=========================================

# ssio_sdr_in_diff_align

Receive-side counterpart of the differential source-synchronous SDR output. It takes WIDTH differential data lanes clocked by the forwarded clock and converts them to single-ended signals with target-specific input buffers. It registers and deserializes each lane by DESER, then finds the word boundary by hunting for a training pattern on lane 0. After a configurable number of consistent pattern hits it emits aligned parallel words. It sits between the pads and the link-layer receive logic, in the forwarded-clock domain.

## Interface

Parameters:
- TARGET, "GENERIC": "SIM", "GENERIC", "XILINX" or "ALTERA"; selects the differential input buffer.
- WIDTH, 1: number of data lanes.
- DESER, 8: deserialization factor, legal range 2..16.
- SYNC_PATTERN, 8'hA5: training word, DESER bits wide; it must not equal any non-trivial rotation of itself.
- LOCK_COUNT, 4: consecutive aligned pattern hits required to lock, range 1..15.

Ports:
- clk, in, 1: forwarded receive clock, already buffered by the clocking wrapper. Only clock.
- rst, in, 1: synchronous, active-high reset.
- input_d_p, in, WIDTH: lane positive legs.
- input_d_n, in, WIDTH: lane negative legs.
- realign, in, 1: forces re-hunt; takes priority over everything except rst.
- output_data, out, WIDTH*DESER: lane n is output_data[n*DESER +: DESER]; the first-received bit is the MSB.
- output_valid, out, 1: single-cycle strobe, one per aligned word.
- locked, out, 1: word alignment is established.

## Operation

Input buffering:
- XILINX: IBUFDS per lane.
- ALTERA: ALT_INBUF_DIFF per lane.
- GENERIC/SIM: use input_d_p; input_d_n is unused.

Datapath:
- Input register: in_reg samples the buffered lanes each clk.
- Per-lane shift register: sreg <= {sreg[DESER-2:0], in_reg}.
- match = (lane-0 sreg == SYNC_PATTERN), evaluated combinationally.
- Phase counter: 0..DESER-1, increments every cycle, wraps DESER-1 -> 0.
- boundary = (phase == DESER-1).

State machine (HUNT, VERIFY, LOCKED; reset state HUNT):
- HUNT:
  - Evaluated every cycle; phase is ignored.
  - On match: phase <= 0 and cnt <= 1.
  - Then go to LOCKED if LOCK_COUNT == 1, otherwise to VERIFY.
- VERIFY:
  - Evaluated only at boundary.
  - On match: cnt++. When cnt+1 == LOCK_COUNT, go to LOCKED.
  - On mismatch: go to HUNT with cnt <= 0.
- LOCKED:
  - At every boundary: output_data <= all lanes' sreg, output_valid <= 1.
  - Words containing SYNC_PATTERN are forwarded unchanged.
  - No automatic loss of lock; the link layer asserts realign.

Entering LOCKED:
- locked <= 1 on the same edge.
- The first emitted word is the word that follows the final verifying sync word.

realign (any state):
- Next edge: state HUNT, cnt 0, locked 0, output_valid 0.
- output_data holds its value.
- If realign coincides with a boundary in LOCKED, no word is emitted.

Reset values:
- output_data 0, output_valid 0, locked 0.
- state HUNT, cnt 0, phase 0, in_reg 0, sreg 0.
- Reset mid-operation aborts any partial word with no strobe.

## Timing

- A bit present at the pins before edge k is in in_reg after edge k and in sreg[0] after edge k+1.
- The last bit of a word sampled at edge k appears on output_data with output_valid high after edge k+2, for exactly one cycle.
- Strobe spacing in LOCKED is exactly DESER cycles.
- A pattern completing in sreg after edge t loads phase 0 at edge t+1.
- The next boundary is the cycle after edge t+DESER.
- locked rises one edge after the boundary cycle of the LOCK_COUNT-th hit.
- The first output_valid follows DESER cycles after that.

## Test plan

Bench configuration: WIDTH=2, DESER=8, SYNC_PATTERN=8'hA5, LOCK_COUNT=4.

1. Reset -> hold rst 3 cycles with random pins -> output_data 0, output_valid 0, locked 0; no strobe for 2 cycles after release.
2. Lock at bit offset 3 -> 3 idle bits, four A5 words on lane 0, then lane 0 = 3C, 96 and lane 1 = C3, 69 -> locked rises one cycle after the 4th A5 boundary; strobes every 8 cycles show lanes {C3,3C} then {69,96}.
3. Failed verify -> three A5 words then 24 -> state HUNT, locked stays 0; then four A5 words -> lock achieved.
4. realign at a LOCKED boundary -> no output_valid that cycle, locked 0 next cycle, output_data unchanged; relock after a fresh A5 sequence.
5. Reset mid-VERIFY -> after two A5 hits assert rst for 1 cycle -> next two A5 words do not lock; four fresh hits are required.
6. False hit in HUNT -> random data containing a single A5 followed by non-A5 words -> locked never asserts and there is no output_valid.

Source files
------------

// File: rtl/ssio_sdr_in_diff_align.sv
`default_nettype none
// ============================================================================
// Module      : ssio_sdr_in_diff_align
// Description : Differential source-synchronous SDR receiver with word
//               alignment. Each of WIDTH differential lanes is buffered,
//               registered and shifted into a DESER-bit deserializer. Lane 0
//               is searched for SYNC_PATTERN to find the word boundary; once
//               LOCK_COUNT consecutive patterns land on the same boundary the
//               block emits one aligned parallel word every DESER cycles.
//
// Ports       : clk           forwarded receive clock (already buffered)
//               rst           synchronous active-high reset
//               input_d_p     lane positive legs   [WIDTH]
//               input_d_n     lane negative legs   [WIDTH]
//               realign       force a new boundary search
//               output_data   aligned words, lane n at [n*DESER +: DESER],
//                             first-received bit in the MSB
//               output_valid  one-cycle strobe per aligned word
//               locked        word alignment established
//
// Revision    : 1.0 - initial release
// ============================================================================
module ssio_sdr_in_diff_align #(
    parameter string             TARGET       = "GENERIC",
    parameter int                WIDTH        = 1,
    parameter int                DESER        = 8,
    parameter logic [DESER-1:0]  SYNC_PATTERN = 8'hA5,
    parameter int                LOCK_COUNT   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         input_d_p,
    input  logic [WIDTH-1:0]         input_d_n,
    input  logic                     realign,
    output logic [WIDTH*DESER-1:0]   output_data,
    output logic                     output_valid,
    output logic                     locked
);

    localparam int              PW           = $clog2(DESER);
    localparam logic [PW-1:0]   c_phase_last = PW'(DESER - 1);
    localparam logic [PW-1:0]   c_phase_one  = PW'(1);
    localparam logic [3:0]      c_lock_count = 4'(LOCK_COUNT);

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------------
    generate
        if (DESER < 2 || DESER > 16) begin : g_bad_deser
            $error("ssio_sdr_in_diff_align: DESER must be in 2..16");
        end
        if (LOCK_COUNT < 1 || LOCK_COUNT > 15) begin : g_bad_lock_count
            $error("ssio_sdr_in_diff_align: LOCK_COUNT must be in 1..15");
        end
        // A pattern equal to one of its own rotations would match at more
        // than one bit offset, making the boundary ambiguous.
        for (genvar r = 1; r < DESER; r++) begin : g_rot_check
            if (((SYNC_PATTERN << r) | (SYNC_PATTERN >> (DESER - r))) == SYNC_PATTERN) begin : g_bad_pattern
                $error("ssio_sdr_in_diff_align: SYNC_PATTERN equals a rotation of itself");
            end
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Differential input buffers
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] w_d_buf;
    // Negative legs are only consumed by vendor primitives.
    logic             w_unused_d_n;
    assign w_unused_d_n = ^input_d_n;

    generate
        if (TARGET == "XILINX") begin : g_xilinx
`ifdef SSIO_VENDOR_PRIMS
            for (genvar n = 0; n < WIDTH; n++) begin : g_lane
                IBUFDS u_ibufds (
                    .I  (input_d_p[n]),
                    .IB (input_d_n[n]),
                    .O  (w_d_buf[n])
                );
            end
`else
            // Vendor libraries are only present in vendor flows, which must
            // define SSIO_VENDOR_PRIMS; refuse to silently build a
            // single-ended receiver for a differential target.
            $error("ssio_sdr_in_diff_align: XILINX target needs SSIO_VENDOR_PRIMS");
            assign w_d_buf = input_d_p;
`endif
        end else if (TARGET == "ALTERA") begin : g_altera
`ifdef SSIO_VENDOR_PRIMS
            for (genvar n = 0; n < WIDTH; n++) begin : g_lane
                ALT_INBUF_DIFF u_inbuf (
                    .i    (input_d_p[n]),
                    .ibar (input_d_n[n]),
                    .o    (w_d_buf[n])
                );
            end
`else
            $error("ssio_sdr_in_diff_align: ALTERA target needs SSIO_VENDOR_PRIMS");
            assign w_d_buf = input_d_p;
`endif
        end else if (TARGET == "GENERIC" || TARGET == "SIM") begin : g_generic
            assign w_d_buf = input_d_p;
        end else begin : g_bad_target
            $error("ssio_sdr_in_diff_align: unknown TARGET");
            assign w_d_buf = input_d_p;
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Input register and per-lane deserializer
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0]            r_in;
    logic [WIDTH-1:0][DESER-1:0] r_sreg;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_in   <= '0;
            r_sreg <= '0;
        end else begin
            r_in <= w_d_buf;
            // Oldest bit drifts toward the MSB, so a complete word has the
            // first-received bit on top.
            for (int n = 0; n < WIDTH; n++) begin
                r_sreg[n] <= {r_sreg[n][DESER-2:0], r_in[n]};
            end
        end
    end

    // ------------------------------------------------------------------------
    // Boundary search and word emission
    // ------------------------------------------------------------------------
    state_t        r_state;
    logic [3:0]    r_cnt;
    logic [PW-1:0] r_phase;

    logic          w_match;
    logic          w_boundary;
    logic [3:0]    w_cnt_inc;

    assign w_match    = (r_sreg[0] == SYNC_PATTERN);
    assign w_boundary = (r_phase == c_phase_last);
    assign w_cnt_inc  = r_cnt + 4'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_HUNT;
            r_cnt        <= '0;
            r_phase      <= '0;
            output_data  <= '0;
            output_valid <= 1'b0;
            locked       <= 1'b0;
        end else begin
            // Free-running word phase; a HUNT hit re-anchors it below.
            r_phase      <= w_boundary ? '0 : r_phase + c_phase_one;
            output_valid <= 1'b0;

            if (realign) begin
                // output_data deliberately keeps the last emitted word.
                r_state <= ST_HUNT;
                r_cnt   <= '0;
                locked  <= 1'b0;
            end else begin
                case (r_state)
                    ST_HUNT: begin
                        // Bit-by-bit search: any cycle may be a boundary.
                        if (w_match) begin
                            r_phase <= '0;
                            r_cnt   <= 4'd1;
                            if (LOCK_COUNT == 1) begin
                                r_state <= ST_LOCKED;
                                locked  <= 1'b1;
                            end else begin
                                r_state <= ST_VERIFY;
                            end
                        end
                    end

                    ST_VERIFY: begin
                        // The pattern must reappear on the same boundary.
                        if (w_boundary) begin
                            if (w_match) begin
                                r_cnt <= w_cnt_inc;
                                if (w_cnt_inc == c_lock_count) begin
                                    r_state <= ST_LOCKED;
                                    locked  <= 1'b1;
                                end
                            end else begin
                                r_state <= ST_HUNT;
                                r_cnt   <= '0;
                            end
                        end
                    end

                    ST_LOCKED: begin
                        // Training words are passed through like any other
                        // word; loss of lock is the link layer's decision.
                        if (w_boundary) begin
                            output_data  <= r_sreg;
                            output_valid <= 1'b1;
                        end
                    end

                    default: begin
                        r_state <= ST_HUNT;
                        r_cnt   <= '0;
                        locked  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ssio_sdr_in_diff_align.sv
`default_nettype none
// ============================================================================
// Module      : tb_ssio_sdr_in_diff_align
// Description : Directed bench for ssio_sdr_in_diff_align (WIDTH=2, DESER=8,
//               SYNC_PATTERN=A5, LOCK_COUNT=4). A timeline model keeps the
//               received bit history and derives alignment from absolute
//               bit positions; the DUT is compared to it every cycle, and a
//               set of hand-computed literals pins the expected behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ssio_sdr_in_diff_align;

    localparam int          WIDTH = 2;
    localparam int          DESER = 8;
    localparam int          LC    = 4;
    localparam logic [7:0]  SYNC  = 8'hA5;
    localparam int          HLEN  = 4096;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        realign = 1'b0;
    logic [1:0]  d_p = 2'b00;
    logic [1:0]  d_n = 2'b11;
    logic [15:0] output_data;
    logic        output_valid;
    logic        locked;

    ssio_sdr_in_diff_align #(
        .TARGET       ("SIM"),
        .WIDTH        (WIDTH),
        .DESER        (DESER),
        .SYNC_PATTERN (SYNC),
        .LOCK_COUNT   (LC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .input_d_p    (d_p),
        .input_d_n    (d_n),
        .realign      (realign),
        .output_data  (output_data),
        .output_valid (output_valid),
        .locked       (locked)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // ------------------------------------------------------------------------
    // Timeline model
    // ------------------------------------------------------------------------
    int   ecount   = 0;        // index of the most recent rising edge
    int   last_rst = -1;       // bits sampled at or before this edge are lost
    bit   h0 [0:HLEN-1];
    bit   h1 [0:HLEN-1];
    bit   model_ready = 1'b0;
    int   m_mode   = 0;        // 0 searching, 1 confirming, 2 aligned
    int   m_hits   = 0;
    int   m_anchor = 0;        // edge after which the first hit completed
    logic        m_locked = 1'b0;
    logic        m_valid  = 1'b0;
    logic [15:0] m_data   = '0;

    // Word held in the deserializer after edge m: bits sampled at edges
    // m-8 .. m-1, earliest bit in the MSB.
    function automatic logic [7:0] word_at(int lane, int m);
        logic [7:0] w;
        int idx;
        w = '0;
        for (int i = 0; i < 8; i++) begin
            idx = m - 8 + i;
            if (idx > last_rst && idx >= 0 && idx < HLEN)
                w[7-i] = (lane == 0) ? h0[idx] : h1[idx];
        end
        return w;
    endfunction

    always @(posedge clk) begin
        logic [7:0] w0;
        logic [7:0] w1;
        ecount = ecount + 1;
        if (ecount < HLEN) begin
            h0[ecount] = d_p[0];
            h1[ecount] = d_p[1];
        end
        if (rst) begin
            last_rst    = ecount;
            m_mode      = 0;
            m_hits      = 0;
            m_locked    = 1'b0;
            m_valid     = 1'b0;
            m_data      = '0;
            model_ready = 1'b1;
        end else if (realign) begin
            m_mode   = 0;
            m_hits   = 0;
            m_locked = 1'b0;
            m_valid  = 1'b0;
        end else begin
            w0 = word_at(0, ecount - 1);
            w1 = word_at(1, ecount - 1);
            m_valid = 1'b0;
            if (m_mode == 0) begin
                if (w0 == SYNC) begin
                    m_anchor = ecount - 1;
                    m_hits   = 1;
                    m_mode   = (LC == 1) ? 2 : 1;
                    if (LC == 1) m_locked = 1'b1;
                end
            end else if (((ecount - 1 - m_anchor) % DESER) == 0) begin
                if (m_mode == 1) begin
                    if (w0 == SYNC) begin
                        m_hits = m_hits + 1;
                        if (m_hits == LC) begin
                            m_mode   = 2;
                            m_locked = 1'b1;
                        end
                    end else begin
                        m_mode = 0;
                        m_hits = 0;
                    end
                end else begin
                    m_valid = 1'b1;
                    m_data  = {w1, w0};
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Per-cycle compare and strobe log
    // ------------------------------------------------------------------------
    logic [15:0] sq_data[$];
    int          sq_edge[$];
    int          lock_edge = -1;
    bit          prev_locked = 1'b0;

    always @(negedge clk) begin
        if (model_ready) begin
            vectors = vectors + 1;
            if (output_data !== m_data || output_valid !== m_valid || locked !== m_locked) begin
                miscompares = miscompares + 1;
                $display("FAIL cycle@edge %0d: dut data=%h valid=%b locked=%b, model data=%h valid=%b locked=%b",
                         ecount, output_data, output_valid, locked, m_data, m_valid, m_locked);
            end
            if (output_valid === 1'b1) begin
                sq_data.push_back(output_data);
                sq_edge.push_back(ecount);
            end
            if (locked === 1'b1 && !prev_locked) lock_edge = ecount;
            prev_locked = (locked === 1'b1);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors = vectors + 1;
        if (act !== exp) begin
            miscompares = miscompares + 1;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic send_bit(input bit b0, input bit b1);
        d_p = {b1, b0};
        d_n = ~d_p;
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [7:0] w0, input logic [7:0] w1);
        for (int i = 7; i >= 0; i--) send_bit(w0[i], w1[i]);
    endtask

    task automatic pulse_realign();
        realign = 1'b1;
        send_bit(1'b0, 1'b0);
        realign = 1'b0;
        for (int i = 0; i < 7; i++) send_bit(1'b0, 1'b0);
        send_word(8'h00, 8'h00);
    endtask

    initial begin : timeout
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin : stim
        int k4;

        // 1. Reset with random pins
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            d_p = 2'($urandom_range(0, 3));
            d_n = ~d_p;
            @(posedge clk);
            #1;
        end
        check("reset_data",   32'(output_data),  32'h0);
        check("reset_valid",  32'(output_valid), 32'h0);
        check("reset_locked", 32'(locked),       32'h0);
        rst = 1'b0;
        send_bit(1'b0, 1'b0);
        check("post_reset_valid_1", 32'(output_valid), 32'h0);
        send_bit(1'b0, 1'b0);
        check("post_reset_valid_2", 32'(output_valid), 32'h0);

        // 2. Lock at bit offset 3
        for (int i = 0; i < 3; i++) send_bit(1'b0, 1'b0);
        sq_data.delete();
        sq_edge.delete();
        repeat (4) send_word(SYNC, 8'h00);
        k4 = ecount;
        check("model_word_order", 32'(word_at(0, k4 + 1)), 32'hA5);
        send_word(8'h3C, 8'hC3);
        send_word(8'h96, 8'h69);
        check("lock_edge", 32'(lock_edge), 32'(k4 + 2));
        send_word(8'hE7, 8'h18);
        check("t2_strobes", 32'(sq_data.size()), 32'd2);
        if (sq_data.size() == 2) begin
            check("t2_word0", 32'(sq_data[0]), 32'hC33C);
            check("t2_word1", 32'(sq_data[1]), 32'h6996);
            check("t2_first_strobe", 32'(sq_edge[0]), 32'(k4 + 10));
            check("t2_spacing", 32'(sq_edge[1] - sq_edge[0]), 32'd8);
        end

        // 4. realign on the boundary that would emit E7/18
        send_bit(1'b0, 1'b0);
        realign = 1'b1;
        send_bit(1'b0, 1'b0);
        realign = 1'b0;
        check("t4_valid", 32'(output_valid), 32'h0);
        check("t4_locked", 32'(locked), 32'h0);
        check("t4_data_hold", 32'(output_data), 32'h6996);
        for (int i = 0; i < 6; i++) send_bit(1'b0, 1'b0);
        send_word(8'h00, 8'h00);
        check("t4_no_strobe", 32'(sq_data.size()), 32'd2);

        // 3. Failed verify, then relock
        sq_data.delete();
        sq_edge.delete();
        repeat (3) send_word(SYNC, 8'h00);
        send_word(8'h24, 8'h00);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        check("t3_locked_after_24", 32'(locked), 32'h0);
        for (int i = 5; i >= 0; i--) send_bit(SYNC[i], 1'b0);
        repeat (3) send_word(SYNC, 8'h00);
        send_word(8'h5A, 8'hF0);
        send_word(8'h00, 8'h00);
        check("t3_locked", 32'(locked), 32'h1);
        check("t3_strobes", 32'(sq_data.size()), 32'd1);
        if (sq_data.size() >= 1) check("t3_word0", 32'(sq_data[0]), 32'hF05A);

        // 5. Reset in the middle of verification
        pulse_realign();
        repeat (2) send_word(SYNC, 8'h00);
        for (int i = 7; i >= 0; i--) begin
            rst = (i == 4);
            send_bit(SYNC[i], 1'b0);
        end
        rst = 1'b0;
        repeat (2) send_word(SYNC, 8'h00);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        check("t5_not_locked", 32'(locked), 32'h0);
        for (int i = 5; i >= 0; i--) send_bit(SYNC[i], 1'b0);
        send_word(SYNC, 8'h00);
        send_word(8'h00, 8'h00);
        check("t5_locked", 32'(locked), 32'h1);

        // 6. Single false hit in HUNT
        pulse_realign();
        sq_data.delete();
        sq_edge.delete();
        send_word(8'h13, 8'h5C);
        send_word(SYNC,  8'h2B);
        send_word(8'h3C, 8'h91);
        send_word(8'h77, 8'hE0);
        send_word(8'h00, 8'h00);
        send_word(8'h00, 8'h00);
        check("t6_locked", 32'(locked), 32'h0);
        check("t6_no_strobe", 32'(sq_data.size()), 32'd0);

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
